// File: rtl/fibonacci.sv
// fibonacci: iterative Fibonacci accelerator. A start pulse captures n, and the
// block then performs one 32-bit addition per clock (modulo 2^32).
// Latency: busy_o is high for n+1 cycles after start is sampled. The result
// updates on the edge where busy_o falls.
// Backpressure: none. start_i is ignored while busy. result_o holds until the
// next completion.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   request pulse, sampled on the rising edge while idle
//   n_i       Fibonacci index, captured together with start_i
//   result_o  F(n) mod 2^32 of the last completed request
//   busy_o    high while a computation is in progress
module fibonacci (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] n_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [31:0] w_a_nxt;
  logic [31:0] w_b_nxt;
  logic [31:0] w_result_nxt;

  // State and datapath registers. Reset also discards any in-flight
  // computation; the aborted request never reaches result_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cnt    <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_result_nxt = r_result;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_cnt_nxt   = n_i;
          w_a_nxt     = 32'd0;
          w_b_nxt     = 32'd1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // (a, b) walks as (F(i), F(i+1)). cnt counts the remaining steps, so
        // a holds F(n) once cnt reaches zero.
        if (r_cnt == 32'd0) begin
          w_result_nxt = r_a;
          w_state_nxt  = IDLE;
        end else begin
          w_a_nxt   = r_b;
          w_b_nxt   = r_a + r_b;
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // busy_o comes straight from the registered state. It therefore rises right
  // after the sampling edge and falls on the same edge that updates result_o.
  assign busy_o   = (r_state == RUN);
  assign result_o = r_result;

endmodule

// File: tb/tb_fibonacci.sv
module tb_fibonacci;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] n_i;
  logic [31:0] result_o;
  logic        busy_o;

  int checks;
  int passed;

  fibonacci dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .n_i      (n_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse start for one cycle, then count the cycles until busy drops.
  // Returns the number of busy cycles (0 if busy never rose).
  task automatic run(input logic [31:0] n, output int lat);
    int cyc;
    n_i     = n;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    if (busy_o !== 1'b1) begin
      lat = 0;
      return;
    end
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (busy_o === 1'b1 && cyc < 300);
    lat = cyc;
  endtask

  logic [31:0] sweep_exp [20] = '{
    32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34,
    32'd55, 32'd89, 32'd144, 32'd233, 32'd377, 32'd610, 32'd987, 32'd1597,
    32'd2584, 32'd4181
  };

  initial begin
    int lat;
    checks  = 0;
    passed  = 0;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    n_i     = 32'd0;

    // Reset held for two cycles.
    step();
    step();
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_ni = 1'b1;
    step();

    // Sweep n = 0..19.
    for (int i = 0; i < 20; i++) begin
      run(i[31:0], lat);
      check($sformatf("sweep_lat_n%0d", i), lat, i + 1);
      check($sformatf("sweep_res_n%0d", i), result_o, sweep_exp[i]);
      step();
    end

    // Latency corner cases.
    run(32'd10, lat);
    check("lat_n10", lat, 32'd11);
    check("res_n10", result_o, 32'd55);
    step();
    run(32'd0, lat);
    check("lat_n0", lat, 32'd1);
    check("res_n0", result_o, 32'd0);
    step();

    // Wrap-around near and past 2^32.
    run(32'd47, lat);
    check("res_n47", result_o, 32'd2971215073);
    step();
    run(32'd48, lat);
    check("res_n48", result_o, 32'd512559680);
    step();
    run(32'd50, lat);
    check("lat_n50", lat, 32'd51);
    check("res_n50", result_o, 32'd3996334433);
    step();

    // A start pulse with a new n_i during RUN must be ignored.
    n_i     = 32'd20;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("ign_busy", {31'd0, busy_o}, 32'd1);
    lat = 1;
    repeat (4) begin
      step();
      lat++;
    end
    n_i     = 32'd5;
    start_i = 1'b1;
    step();
    lat++;
    start_i = 1'b0;
    while (busy_o === 1'b1 && lat < 300) begin
      step();
      lat++;
    end
    // lat counts from the sampling edge, so a full n=20 run gives 21 busy cycles plus that edge.
    check("ign_lat", lat - 1, 32'd21);
    check("ign_res", result_o, 32'd6765);
    start_i = 1'b1;  // held start would begin a new run here; keep it low to test the hold
    start_i = 1'b0;
    repeat (3) step();
    check("ign_hold_res", result_o, 32'd6765);
    check("ign_hold_busy", {31'd0, busy_o}, 32'd0);

    // Reset mid-run, asserted between clock edges.
    n_i     = 32'd30;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (10) step();
    check("mid_busy_before", {31'd0, busy_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    step();
    rst_ni = 1'b1;
    step();
    run(32'd3, lat);
    check("post_rst_lat", lat, 32'd4);
    check("post_rst_res", result_o, 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
